// File: rtl/arithmetic_logic_unit.sv
// 32-bit MIPS-style ALU with a registered result stage.
// The zero flag is decoded from the result register so it always matches result.
module arithmetic_logic_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucontrol,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             slt;
    logic [WIDTH-1:0] result_next;

    // alucontrol[2] inverts b for ANDN/ORN and turns the shared adder into a subtractor
    always_comb begin
        b_eff = alucontrol[2] ? ~b : b;
        sum   = a + b_eff + WIDTH'(alucontrol[2]);
        slt   = (a[MSB] != b[MSB]) ? a[MSB] : sum[MSB];
    end

    always_comb begin
        result_next = '0;
        unique case (alucontrol[1:0])
            2'b00: result_next = a & b_eff;
            2'b01: result_next = a | b_eff;
            2'b10: result_next = sum;
            2'b11: result_next = alucontrol[2] ? WIDTH'(slt) : (a ^ b);
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
        end else begin
            result <= result_next;
        end
    end

    assign zero = ~|result;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed and random bench for arithmetic_logic_unit, scoreboarded via a queue of expected results.
module tb_arithmetic_logic_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alucontrol;
    logic [31:0] result;
    logic        zero;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    arithmetic_logic_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .result     (result),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x + y;
            3'd3: return x ^ y;
            3'd4: return x & ~y;
            3'd5: return x | ~y;
            3'd6: return x - y;
            default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // drive at the falling edge and record what the next rising edge must produce
    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op, input logic [31:0] expv);
        @(negedge clk);
        a = x;
        b = y;
        alucontrol = op;
        exp_q.push_back(expv);
    endtask

    task automatic sample(input string tag);
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=scoreboard-empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check32(tag, result, e);
            check1({tag, "_zero"}, zero, (e == 32'd0));
        end
    endtask

    task automatic op_k(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [2:0] op, input logic [31:0] expv);
        drive(x, y, op, expv);
        sample(tag);
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        logic [2:0]  rop;
        reset = 1'b0;
        a = '0;
        b = '0;
        alucontrol = '0;
        #1 reset = 1'b1;
        #2;
        check32("reset_result", result, 32'd0);
        check1("reset_zero", zero, 1'b1);

        // operations are ignored while reset is held
        @(negedge clk);
        a = 32'd5;
        b = 32'd3;
        alucontrol = 3'b010;
        @(posedge clk);
        #1;
        check32("reset_hold_result", result, 32'd0);
        check1("reset_hold_zero", zero, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        op_k("slt_84_85", 32'd84, 32'd85, 3'b111, 32'd1);
        op_k("slt_85_84", 32'd85, 32'd84, 3'b111, 32'd0);
        op_k("slt_m1_1", 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1);
        op_k("slt_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'd0);
        op_k("slt_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'd1);
        op_k("slt_equal", 32'd7, 32'd7, 3'b111, 32'd0);
        op_k("add_wrap", 32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0);
        op_k("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'b010, 32'h8000_0000);
        op_k("sub_10_3", 32'd10, 32'd3, 3'b110, 32'd7);
        op_k("sub_min_1", 32'h8000_0000, 32'd1, 3'b110, 32'h7FFF_FFFF);
        op_k("sub_equal", 32'h1234_5678, 32'h1234_5678, 3'b110, 32'd0);
        op_k("sub_wrap", 32'd0, 32'd1, 3'b110, 32'hFFFF_FFFF);
        op_k("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000);
        op_k("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0);
        op_k("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'h0FF0_0FF0);
        op_k("andn", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h00F0_00F0);
        op_k("orn", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 32'hF0FF_F0FF);

        // input changes between edges must not reach the output
        op_k("hold_base", 32'd100, 32'd23, 3'b010, 32'd123);
        a = 32'd0;
        b = 32'd0;
        alucontrol = 3'b000;
        #2;
        check32("hold_between_edges", result, 32'd123);

        // back-to-back random burst against the reference model
        for (int i = 0; i < 24; i++) begin
            rx  = $urandom;
            ry  = (i % 4 == 0) ? rx : $urandom;
            rop = 3'($urandom_range(0, 7));
            op_k("rand", rx, ry, rop, model(rx, ry, rop));
        end

        // asynchronous reset mid-burst with an operation in flight
        op_k("pre_reset", 32'd40, 32'd2, 3'b010, 32'd42);
        drive(32'd9, 32'd9, 3'b001, 32'd9);
        #2 reset = 1'b1;
        #1;
        check32("async_reset_result", result, 32'd0);
        check1("async_reset_zero", zero, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        check32("reset_after_edge", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        op_k("post_reset", 32'd6, 32'd4, 3'b110, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
